// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD fill scheduler.
//   CMD_*      : panel command bytes (column set, row set, memory write)
//   state_t    : scheduler state enumeration
//   rect_t     : fill rectangle {x0,x1,y0,y1}, 8 bits per field
//   rect_area  : pixel count of a legal rectangle (16-bit result)
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [7:0] y0;
        logic [7:0] y1;
    } rect_t;

    // Only meaningful for rectangles with x0<=x1 and y0<=y1; the largest
    // legal screen area fits comfortably in 16 bits.
    function automatic logic [15:0] rect_area(input rect_t r);
        logic [15:0] w;
        logic [15:0] h;
        w = 16'(r.x1) - 16'(r.x0) + 16'd1;
        h = 16'(r.y1) - 16'(r.y0) + 16'd1;
        return w * h;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, resetn : clock, asynchronous active-low reset
//   req         : request bits (already qualified by the caller)
//   grant       : one-hot grant, combinational; a grant is an acceptance
//   grant_idx   : index of the granted requester
// The pointer remembers the last accepted requester; reset makes requester 0
// the favoured one on the first contention.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_q;

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                if (last_q) begin
                    grant     = 2'b01;
                    grant_idx = 1'b0;
                end else begin
                    grant     = 2'b10;
                    grant_idx = 1'b1;
                end
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/lcd_fill_scheduler.sv
// LCD rectangle fill scheduler: arbitrates two requesters and emits the
// CASET / RASET / RAMWR command sequence followed by the pixel stream as
// 9-bit {rs,byte} words toward an SPI byte shifter.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (bit i = requester i)
//   req_rect             : {x0,x1,y0,y1} per requester (32 bits each)
//   req_color            : RGB565 per requester (16 bits each)
//   wr_valid/wr_ready    : word handshake toward the shifter
//   wr_rs, wr_data       : 0=command / 1=data, byte value
//   busy, grant_id       : transfer in progress, requester being served
//   done, err            : one-cycle end-of-fill / rejected-request pulses
module lcd_fill_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned COL_OFS = 40,
    parameter int unsigned ROW_OFS = 53,
    parameter int unsigned MAX_X   = 239,
    parameter int unsigned MAX_Y   = 134
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_rect,
    input  logic [31:0] req_color,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        wr_rs,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        err
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    rect_t       rect_q;
    logic [15:0] color_q;
    logic [15:0] pix_cnt_q;

    logic [1:0]  arb_req;
    logic [1:0]  arb_grant;
    logic        arb_idx;
    logic        accept;
    rect_t       in_rect;
    logic [15:0] in_color;
    logic        in_bad;
    logic        fire;
    logic        last_pix;
    logic [8:0]  word;
    logic [15:0] x_start;
    logic [15:0] x_end;
    logic [15:0] y_start;
    logic [15:0] y_end;

    // Word k of a 5-word address-set group: command, then start hi/lo, end hi/lo.
    function automatic logic [8:0] word_sel(input logic [2:0] idx, input logic [7:0] cmd,
                                            input logic [15:0] a, input logic [15:0] b);
        case (idx)
            3'd0:    return {1'b0, cmd};
            3'd1:    return {1'b1, a[15:8]};
            3'd2:    return {1'b1, a[7:0]};
            3'd3:    return {1'b1, b[15:8]};
            3'd4:    return {1'b1, b[7:0]};
            default: return {1'b1, 8'hFF};
        endcase
    endfunction

    // Requests are only visible to the arbiter in IDLE and out of reset, so
    // req_ready is low everywhere else without a separate gate.
    assign arb_req = req_valid & {2{(state_q == ST_IDLE) && resetn}};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (arb_req),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = arb_grant;
    assign accept    = |arb_grant;
    assign in_rect   = arb_idx ? rect_t'(req_rect[63:32]) : rect_t'(req_rect[31:0]);
    assign in_color  = arb_idx ? req_color[31:16] : req_color[15:0];
    assign in_bad    = (in_rect.x0 > in_rect.x1) || (in_rect.y0 > in_rect.y1) ||
                       (32'(in_rect.x1) > MAX_X) || (32'(in_rect.y1) > MAX_Y);

    assign x_start  = 16'(rect_q.x0) + 16'(COL_OFS);
    assign x_end    = 16'(rect_q.x1) + 16'(COL_OFS);
    assign y_start  = 16'(rect_q.y0) + 16'(ROW_OFS);
    assign y_end    = 16'(rect_q.y1) + 16'(ROW_OFS);

    assign fire     = wr_valid & wr_ready;
    assign last_pix = (pix_cnt_q == 16'd1);
    assign busy     = (state_q != ST_IDLE);
    assign wr_rs    = word[8];
    assign wr_data  = word[7:0];

    // Outputs are decoded from held state only, so they stay stable while
    // wr_ready is low.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_valid = 1'b0;
        word     = {1'b1, 8'hFF};
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_bad) begin
                    state_d = ST_CASET;
                    idx_d   = '0;
                end
            end
            ST_CASET: begin
                wr_valid = 1'b1;
                word     = word_sel(idx_q, CMD_CASET, x_start, x_end);
                if (wr_ready) begin
                    if (idx_q == 3'd4) begin
                        state_d = ST_RASET;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_RASET: begin
                wr_valid = 1'b1;
                word     = word_sel(idx_q, CMD_RASET, y_start, y_end);
                if (wr_ready) begin
                    if (idx_q == 3'd4) begin
                        state_d = ST_RAMWR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_RAMWR: begin
                wr_valid = 1'b1;
                word     = {1'b0, CMD_RAMWR};
                if (wr_ready) begin
                    state_d = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                wr_valid = 1'b1;
                word     = {1'b1, color_q[15:8]};
                if (wr_ready) begin
                    state_d = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                wr_valid = 1'b1;
                word     = {1'b1, color_q[7:0]};
                if (wr_ready) begin
                    state_d = last_pix ? ST_IDLE : ST_PIX_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rect_q    <= '0;
            color_q   <= '0;
            pix_cnt_q <= '0;
            grant_id  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done    <= fire && (state_q == ST_PIX_LO) && last_pix;
            err     <= accept && in_bad;
            if (accept) begin
                grant_id <= arb_idx;
                if (!in_bad) begin
                    rect_q    <= in_rect;
                    color_q   <= in_color;
                    pix_cnt_q <= rect_area(in_rect);
                end
            end else if (fire && (state_q == ST_PIX_LO)) begin
                pix_cnt_q <= pix_cnt_q - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_fill_scheduler.sv
`timescale 1ns/1ps
module tb_lcd_fill_scheduler;

    localparam int unsigned COL_OFS = 40;
    localparam int unsigned ROW_OFS = 53;
    localparam int unsigned MAX_X   = 239;
    localparam int unsigned MAX_Y   = 134;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_rect = '0;
    logic [31:0] req_color = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        busy;
    logic        grant_id;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int acc_cyc, first_cyc, last_cyc, done_cyc;
    bit stable_ok;

    always #5 clk = ~clk;

    lcd_fill_scheduler #(
        .COL_OFS (COL_OFS),
        .ROW_OFS (ROW_OFS),
        .MAX_X   (MAX_X),
        .MAX_Y   (MAX_Y)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rect  (req_rect),
        .req_color (req_color),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done),
        .err       (err)
    );

    function automatic logic [31:0] mk_rect(input int x0, input int x1, input int y0, input int y1);
        return {8'(x0), 8'(x1), 8'(y0), 8'(y1)};
    endfunction

    // Reference: the word stream a rectangle must produce, appended to exp_q.
    task automatic model_words(input logic [31:0] r, input logic [15:0] c);
        int unsigned x0, x1, y0, y1, xs, xe, ys, ye, n;
        x0 = r[31:24]; x1 = r[23:16]; y0 = r[15:8]; y1 = r[7:0];
        xs = (x0 + COL_OFS) % 65536; xe = (x1 + COL_OFS) % 65536;
        ys = (y0 + ROW_OFS) % 65536; ye = (y1 + ROW_OFS) % 65536;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(xs / 256)}); exp_q.push_back({1'b1, 8'(xs % 256)});
        exp_q.push_back({1'b1, 8'(xe / 256)}); exp_q.push_back({1'b1, 8'(xe % 256)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(ys / 256)}); exp_q.push_back({1'b1, 8'(ys % 256)});
        exp_q.push_back({1'b1, 8'(ye / 256)}); exp_q.push_back({1'b1, 8'(ye % 256)});
        exp_q.push_back({1'b0, 8'h2C});
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    function automatic int words_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) d++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = '0; wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Drives one request from requester id and records the words it produces,
    // the handshake cycles, and whether every stalled word held stable.
    task automatic run_rect(input int id, input logic [31:0] r, input logic [15:0] c,
                            input bit rnd, input int budget);
        bit acc = 0;
        bit prev_stall = 0;
        logic [9:0] prev_out = '0;
        got_q = {}; acc_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1; stable_ok = 1;
        req_rect = {$urandom, $urandom}; req_color = $urandom;
        if (id == 0) begin req_rect[31:0] = r; req_color[15:0] = c; end
        else begin req_rect[63:32] = r; req_color[31:16] = c; end
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (acc) begin
                req_valid = '0;
                req_rect = {$urandom, $urandom};
                req_color = $urandom;
            end else begin
                req_valid = (id == 0) ? 2'b01 : 2'b10;
            end
            wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (done) begin done_cyc = cyc; break; end
            if (prev_stall && {wr_valid, wr_rs, wr_data} !== prev_out) stable_ok = 0;
            if (wr_valid && wr_ready) begin
                got_q.push_back({wr_rs, wr_data});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_out = {wr_valid, wr_rs, wr_data};
            if (!acc && req_ready[id]) begin acc = 1; acc_cyc = cyc; end
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 2'b11; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        total++;
        if ({wr_valid, wr_rs, wr_data} !== {1'b0, 1'b1, 8'hFF}) begin
            bad++; $display("FAIL reset_wr: got %b/%b/%h want 0/1/ff", wr_valid, wr_rs, wr_data);
        end
        total++;
        if ({busy, grant_id, done, err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {busy, grant_id, done, err});
        end
        req_valid = '0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total++;
        if ({busy, wr_valid} !== 2'b00) begin bad++; $display("FAIL reset_release: got %b want 00", {busy, wr_valid}); end
    endtask

    task automatic test_single();
        logic [8:0] lit [13] = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h128, 9'h02B,
                                 9'h100, 9'h135, 9'h100, 9'h135, 9'h02C, 9'h1F8, 9'h100};
        int d = 0;
        exp_q = {};
        model_words(mk_rect(0, 0, 0, 0), 16'hF800);
        run_rect(0, mk_rect(0, 0, 0, 0), 16'hF800, 0, 200);
        if (got_q.size() != 13) d++;
        for (int i = 0; i < 13 && i < got_q.size(); i++) if (got_q[i] !== lit[i]) d++;
        total++;
        if (d != 0) begin bad++; $display("FAIL single_literal: got %0d diffs want 0", d); end
        total++;
        if (words_diff() != 0) begin bad++; $display("FAIL single_model: got %0d diffs want 0", words_diff()); end
        total++;
        if (first_cyc != acc_cyc + 1) begin bad++; $display("FAIL single_latency: got first=%0d want %0d", first_cyc, acc_cyc + 1); end
        total++;
        if (last_cyc - first_cyc + 1 != 13) begin bad++; $display("FAIL single_cycles: got %0d want 13", last_cyc - first_cyc + 1); end
        total++;
        if (done_cyc != last_cyc + 1) begin bad++; $display("FAIL single_done: got cycle %0d want %0d", done_cyc, last_cyc + 1); end
        @(negedge clk); #1;
        total++;
        if ({done, busy, wr_valid} !== 3'b000) begin bad++; $display("FAIL single_after: got %b want 000", {done, busy, wr_valid}); end
    endtask

    task automatic test_stall();
        logic [31:0] rects [2];
        logic [15:0] c;
        rects[0] = mk_rect(0, 0, 0, 0); rects[1] = mk_rect(7, 9, 20, 21);
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? 16'hF800 : 16'($urandom);
            exp_q = {};
            model_words(rects[k], c);
            run_rect(k, rects[k], c, 1, 400);
            total++;
            if (words_diff() != 0) begin bad++; $display("FAIL stall_words[%0d]: got %0d diffs want 0", k, words_diff()); end
            total++;
            if (!stable_ok) begin bad++; $display("FAIL stall_stable[%0d]: got unstable want stable", k); end
            total++;
            if (done_cyc < 0) begin bad++; $display("FAIL stall_done[%0d]: got no done want done", k); end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] r0, r1;
        logic [15:0] c0, c1;
        int ph = 0;
        bit finished = 0;
        apply_reset();
        r0 = mk_rect(1, 1, 2, 2); r1 = mk_rect(3, 4, 5, 5);
        c0 = 16'($urandom); c1 = 16'($urandom);
        exp_q = {}; got_q = {};
        model_words(r0, c0); model_words(r1, c1);
        @(negedge clk);
        req_rect = {r1, r0}; req_color = {c1, c0}; req_valid = 2'b11; wr_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL rr_first_ready: got %b want 01", req_ready); end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (ph == 2) req_valid = '0;
            #1;
            if (cyc == 0) begin
                total++;
                if ({grant_id, busy} !== 2'b01) begin bad++; $display("FAIL rr_grant0: got %b want 01", {grant_id, busy}); end
            end
            if (wr_valid && wr_ready) got_q.push_back({wr_rs, wr_data});
            if (done) begin
                if (ph == 0) begin
                    total++;
                    if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_second_ready: got %b want 10", req_ready); end
                    ph = 1;
                end else if (ph == 2) begin
                    finished = 1;
                    break;
                end
            end else if (ph == 1) begin
                total++;
                if ({grant_id, busy} !== 2'b11) begin bad++; $display("FAIL rr_grant1: got %b want 11", {grant_id, busy}); end
                ph = 2;
            end
        end
        req_valid = '0;
        total++;
        if (!finished) begin bad++; $display("FAIL rr_timeout: got phase %0d want complete", ph); end
        total++;
        if (words_diff() != 0) begin bad++; $display("FAIL rr_words: got %0d diffs want 0", words_diff()); end
    endtask

    task automatic test_reject();
        logic [31:0] tab [4];
        int words;
        tab[0] = mk_rect(10, 5, 0, 0); tab[1] = mk_rect(0, 240, 0, 0);
        tab[2] = mk_rect(0, 0, 3, 2);  tab[3] = mk_rect(0, 0, 0, 135);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_rect = {$urandom, $urandom}; req_rect[31:0] = tab[k];
            req_valid = 2'b01; wr_ready = 1'b1;
            #1;
            total++;
            if (req_ready !== 2'b01) begin bad++; $display("FAIL rej_ready[%0d]: got %b want 01", k, req_ready); end
            @(negedge clk);
            req_valid = '0;
            #1;
            total++;
            if ({err, busy, wr_valid} !== 3'b100) begin bad++; $display("FAIL rej_err[%0d]: got %b want 100", k, {err, busy, wr_valid}); end
            words = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); #1;
                if (wr_valid || busy || err) words++;
            end
            total++;
            if (words != 0) begin bad++; $display("FAIL rej_quiet[%0d]: got %0d active cycles want 0", k, words); end
        end
        // Last accept came from requester 0, so contention now favours 1.
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b10) begin bad++; $display("FAIL rej_pointer: got %b want 10", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int fired = 0;
        bit reached = 0;
        int words = 0;
        logic [15:0] c;
        @(negedge clk);
        req_rect = {$urandom, $urandom}; req_rect[31:0] = mk_rect(0, 1, 0, 1);
        req_valid = 2'b01; wr_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1) req_valid = '0;
            #1;
            if (wr_valid && fired == 14) begin reached = 1; break; end
            if (wr_valid && wr_ready) fired++;
        end
        total++;
        if (!reached) begin bad++; $display("FAIL rst_mid_reach: got %0d words want 14", fired); end
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({req_ready, wr_valid, wr_rs, wr_data, busy, grant_id, done, err} !== {2'b00, 1'b0, 1'b1, 8'hFF, 4'b0000}) begin
            bad++;
            $display("FAIL rst_mid_async: got %b want %b",
                     {req_ready, wr_valid, wr_rs, wr_data, busy, grant_id, done, err},
                     {2'b00, 1'b0, 1'b1, 8'hFF, 4'b0000});
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (wr_valid || busy || done) words++;
        end
        total++;
        if (words != 0) begin bad++; $display("FAIL rst_mid_residual: got %0d active cycles want 0", words); end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_mid_pointer: got %b want 01", req_ready); end
        req_valid = '0;
        c = 16'($urandom);
        exp_q = {};
        model_words(mk_rect(5, 6, 7, 7), c);
        run_rect(1, mk_rect(5, 6, 7, 7), c, 0, 200);
        total++;
        if (got_q.size() == 0 || got_q[0] !== 9'h02A) begin
            bad++; $display("FAIL rst_mid_restart: got %h want 02a", (got_q.size() == 0) ? 9'h1FF : got_q[0]);
        end
        total++;
        if (words_diff() != 0) begin bad++; $display("FAIL rst_mid_words: got %0d diffs want 0", words_diff()); end
    endtask

    task automatic test_random();
        int x0, x1, y0, y1, id;
        logic [15:0] c;
        for (int k = 0; k < 8; k++) begin
            x0 = $urandom_range(0, MAX_X); x1 = x0 + $urandom_range(0, 3);
            if (x1 > MAX_X) x1 = MAX_X;
            y0 = $urandom_range(0, MAX_Y); y1 = y0 + $urandom_range(0, 3);
            if (y1 > MAX_Y) y1 = MAX_Y;
            id = $urandom_range(0, 1);
            c = 16'($urandom);
            exp_q = {};
            model_words(mk_rect(x0, x1, y0, y1), c);
            run_rect(id, mk_rect(x0, x1, y0, y1), c, 1, 1000);
            total++;
            if (words_diff() != 0 || !stable_ok || done_cyc < 0) begin
                bad++;
                $display("FAIL random[%0d]: got diffs=%0d stable=%0b done=%0d want 0/1/seen",
                         k, words_diff(), stable_ok, done_cyc);
            end
        end
    endtask

    task automatic test_full_screen();
        logic [8:0] hdr [8] = '{9'h100, 9'h128, 9'h101, 9'h117, 9'h100, 9'h135, 9'h100, 9'h1BB};
        int d = 0;
        logic [15:0] c;
        c = 16'($urandom);
        exp_q = {};
        model_words(mk_rect(0, 239, 0, 134), c);
        run_rect(0, mk_rect(0, 239, 0, 134), c, 0, 70000);
        if (got_q.size() < 10) d++;
        else for (int i = 0; i < 4; i++) begin
            if (got_q[1 + i] !== hdr[i]) d++;
            if (got_q[6 + i] !== hdr[4 + i]) d++;
        end
        total++;
        if (d != 0) begin bad++; $display("FAIL full_header: got %0d diffs want 0", d); end
        total++;
        if (got_q.size() != 64811) begin bad++; $display("FAIL full_count: got %0d want 64811", got_q.size()); end
        total++;
        if (words_diff() != 0) begin bad++; $display("FAIL full_words: got %0d diffs want 0", words_diff()); end
        total++;
        if (last_cyc - first_cyc + 1 != 64811 || done_cyc != last_cyc + 1) begin
            bad++; $display("FAIL full_timing: got span=%0d done=%0d want 64811/%0d",
                            last_cyc - first_cyc + 1, done_cyc, last_cyc + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_round_robin();
        test_reject();
        test_reset_mid();
        test_random();
        test_full_screen();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_fill_scheduler.md
LCD_FILL_SCHEDULER -- requirements
Module: lcd_fill_scheduler

Interface
REQ-001 SHALL have parameter COL_OFS, default 40, column offset added to every x coordinate.
REQ-002 SHALL have parameter ROW_OFS, default 53, row offset added to every y coordinate.
REQ-003 SHALL have parameter MAX_X, default 239, largest legal x; MAX_Y, default 134, largest legal y.
REQ-004 SHALL have port clk  in  1  single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  2  per-requester fill request (bit i = requester i).
REQ-007 SHALL have port req_ready  out  2  per-requester accept; a request is taken on a cycle where valid&ready.
REQ-008 SHALL have port req_rect  in  64  {x0,x1,y0,y1} 8 bits each; requester 0 in [31:0], requester 1 in [63:32].
REQ-009 SHALL have port req_color  in  32  RGB565 fill colour; requester 0 in [15:0], requester 1 in [31:16].
REQ-010 SHALL have port wr_valid  out  1  a 9-bit word toward the SPI byte shifter is valid.
REQ-011 SHALL have port wr_ready  in  1  the shifter accepts the word on a cycle where wr_valid&wr_ready.
REQ-012 SHALL have port wr_rs  out  1  0 = command byte, 1 = data byte.
REQ-013 SHALL have port wr_data  out  8  byte to shift out MSB first.
REQ-014 SHALL have ports busy  out  1 (not IDLE), grant_id  out  1 (requester being served), done  out  1 (one-cycle end pulse), err  out  1 (one-cycle reject pulse).

Function
REQ-015 SHALL implement states IDLE, CASET (1 cmd + 4 data), RASET (1 cmd + 4 data), RAMWR (1 cmd), PIX_HI, PIX_LO.
REQ-016 SHALL, in IDLE only, grant round-robin between asserted req_valid bits: if both are asserted, grant the requester not served last; otherwise grant the single one.
REQ-017 SHALL drive req_ready combinationally high only for the granted requester in IDLE; both bits are 0 in all other states.
REQ-018 SHALL latch rect and colour on acceptance; wr_valid SHALL rise on the next cycle.
REQ-019 SHALL reject a request with x0>x1, y0>y1, x1>MAX_X or y1>MAX_Y: accept it, pulse err for one cycle, emit no words, remain in IDLE, and still update the round-robin pointer.
REQ-020 SHALL emit, in order: {0,0x2A}, {1,(x0+COL_OFS)[15:8]}, {1,(x0+COL_OFS)[7:0]}, {1,(x1+COL_OFS)[15:8]}, {1,(x1+COL_OFS)[7:0]}, {0,0x2B}, the same four-byte pattern for y0/y1 with ROW_OFS, {0,0x2C}, then N pixels of {1,color[15:8]}, {1,color[7:0]}.
REQ-021 SHALL compute offsets with 16-bit unsigned arithmetic; N=(x1-x0+1)*(y1-y0+1) SHALL be held in a 16-bit counter (at most 32400).
REQ-022 SHALL advance exactly one word per wr_valid&wr_ready cycle; while wr_ready=0, wr_valid, wr_rs and wr_data SHALL hold stable.
REQ-023 SHALL emit 11+2N words per accepted rectangle; with wr_ready held at 1 they occupy 11+2N consecutive cycles.
REQ-024 SHALL, on the handshake of the last PIX_LO, return to IDLE, deassert wr_valid, and pulse done in the following cycle; a new request may be accepted in that same cycle.
REQ-025 SHALL ignore req_valid changes while not in IDLE.

Reset
REQ-026 SHALL, while resetn=0, force state IDLE, req_ready=0, wr_valid=0, wr_rs=1, wr_data=0xFF, busy=0, grant_id=0, done=0, err=0, pixel counter=0, and round-robin pointer favouring requester 0.
REQ-027 SHALL abandon any in-progress rectangle immediately on reset assertion, with no further words emitted after release.

Structure
REQ-028 SHALL take command constants (0x2A, 0x2B, 0x2C), the state enumeration and the rect struct {x0,x1,y0,y1} from shared package lcd_pkg.
REQ-029 SHALL instantiate one sub-module, rr_arbiter2 (two-way round-robin grant with pointer update on accept).

Verification
REQ-030 SHALL cover: requester 0 rect (0,0,0,0), colour 0xF800, wr_ready=1 -> words 02A,100,128,100,128,02B,100,135,100,135,02C,1F8,100; done pulse; 13 cycles.
REQ-031 SHALL cover: full-screen rect (0,239,0,134) -> column bytes 100,128,101,117; row bytes 100,135,100,1BB; 32400 pixels; 64811 words.
REQ-032 SHALL cover: both req_valid asserted after reset -> requester 0 served first, then requester 1; grant_id 0 then 1.
REQ-033 SHALL cover: wr_ready toggled randomly -> word sequence identical to REQ-030 and outputs stable across every stall.
REQ-034 SHALL cover: rect x0=10, x1=5 -> req_ready for one cycle, one-cycle err pulse, zero words emitted, busy stays 0.
REQ-035 SHALL cover: resetn asserted during PIX_LO -> all outputs take REQ-026 values asynchronously; after release no residual words and next request starts with 02A.
